// File: rtl/scanline_fifo_fwft.sv
// scanline_fifo_fwft
// Single-clock first-word-fall-through FIFO for 128-bit pixel words. It sits
// between the memory read-data path and the scan-out logic. Its port names
// and flag behaviour match the vendor FIFO it replaces, so the existing flush
// handshake keeps working.
//
// Ports
//   clk            sole clock, rising edge
//   reset_n        synchronous active-low full reset
//   rst            synchronous active-high flush (same effect as reset_n low)
//   wr_en / din    write request and data
//   full, almost_full, prog_full   write-side level flags (registered)
//   wr_ack / overflow              one-cycle pulses for last cycle's write
//   wr_data_count                  occupancy
//   wr_rst_busy                    reset in progress, requests ignored
//   rd_en                          pop the head word
//   dout, empty, data_valid        FWFT head word and its validity
//   almost_empty, prog_empty       read-side level flags (registered)
//   underflow                      one-cycle pulse for last cycle's read
//   rd_data_count, rd_rst_busy     mirrors of the write-side signals
//
// Handshake: a write takes effect on an edge where wr_en=1, full=0 and busy=0.
// A read takes effect on an edge where rd_en=1, empty=0 and busy=0. Flags are
// evaluated before the edge, so a blocked request is reported by a pulse
// (overflow/underflow) in the next cycle and changes nothing.
module scanline_fifo_fwft #(
  parameter int FIFO_WRITE_DEPTH  = 512,
  parameter int WRITE_DATA_WIDTH  = 128,
  parameter int PROG_FULL_THRESH  = 500,
  parameter int PROG_EMPTY_THRESH = 10,
  parameter int RST_BUSY_CYCLES   = 4,
  localparam int AW  = $clog2(FIFO_WRITE_DEPTH),
  localparam int CW  = AW + 1,
  localparam int BCW = $clog2(RST_BUSY_CYCLES + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WRITE_DATA_WIDTH-1:0] din,
  output logic                        full,
  output logic                        almost_full,
  output logic                        prog_full,
  output logic                        wr_ack,
  output logic                        overflow,
  output logic [CW-1:0]               wr_data_count,
  output logic                        wr_rst_busy,
  input  logic                        rd_en,
  output logic [WRITE_DATA_WIDTH-1:0] dout,
  output logic                        empty,
  output logic                        almost_empty,
  output logic                        prog_empty,
  output logic                        data_valid,
  output logic                        underflow,
  output logic [CW-1:0]               rd_data_count,
  output logic                        rd_rst_busy
);

  logic [WRITE_DATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];

  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic [CW-1:0]               mem_cnt;
  logic                        valid_q, valid_d;
  logic [WRITE_DATA_WIDTH-1:0] dout_q;
  logic [BCW-1:0]              busy_cnt_q, busy_cnt_d;
  logic                        busy_q, busy_d;
  logic                        full_q, almost_full_q, prog_full_q;
  logic                        almost_empty_q, prog_empty_q;
  logic                        wr_ack_q, overflow_q, underflow_q;
  logic                        rst_src, wr_acc, rd_acc, load;

  assign rst_src = ~reset_n | rst;

  always_comb begin
    wr_acc     = wr_en & ~full_q & ~busy_q;
    rd_acc     = rd_en & valid_q & ~busy_q;
    // Words still in the array, i.e. not yet moved into the output register.
    mem_cnt    = count_q - CW'(valid_q);
    // Refill the output register when it is vacant or being popped. Only
    // words already in the array before this edge qualify, which produces the
    // one-cycle write-to-visible latency.
    load       = (rd_acc | ~valid_q) & (mem_cnt != '0);
    count_d    = count_q + CW'(wr_acc) - CW'(rd_acc);
    valid_d    = load | (valid_q & ~rd_acc);
    wr_ptr_d   = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
    busy_cnt_d = (busy_cnt_q != '0) ? busy_cnt_q - BCW'(1) : busy_cnt_q;
    busy_d     = (busy_cnt_q != '0);
  end

  // Storage array: not reset; a flush only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_src) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      valid_q        <= 1'b0;
      dout_q         <= '0;
      busy_cnt_q     <= BCW'(RST_BUSY_CYCLES);
      busy_q         <= 1'b1;
      full_q         <= 1'b1;
      almost_full_q  <= 1'b1;
      prog_full_q    <= 1'b1;
      almost_empty_q <= 1'b1;
      prog_empty_q   <= 1'b1;
      wr_ack_q       <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      if (load) begin
        dout_q <= mem[rd_ptr_q];
      end
      busy_cnt_q     <= busy_cnt_d;
      busy_q         <= busy_d;
      // Write-side flags read as asserted for as long as busy is high.
      full_q         <= busy_d | (count_d == CW'(FIFO_WRITE_DEPTH));
      almost_full_q  <= busy_d | (count_d >= CW'(FIFO_WRITE_DEPTH - 1));
      prog_full_q    <= busy_d | (count_d >= CW'(PROG_FULL_THRESH));
      almost_empty_q <= (count_d <= CW'(1));
      prog_empty_q   <= (count_d <= CW'(PROG_EMPTY_THRESH));
      wr_ack_q       <= wr_acc;
      overflow_q     <= wr_en & full_q & ~busy_q;
      underflow_q    <= rd_en & ~valid_q & ~busy_q;
    end
  end

  assign full          = full_q;
  assign almost_full   = almost_full_q;
  assign prog_full     = prog_full_q;
  assign wr_ack        = wr_ack_q;
  assign overflow      = overflow_q;
  assign wr_data_count = count_q;
  assign wr_rst_busy   = busy_q;
  assign dout          = dout_q;
  assign empty         = ~valid_q;
  assign almost_empty  = almost_empty_q;
  assign prog_empty    = prog_empty_q;
  assign data_valid    = valid_q;
  assign underflow     = underflow_q;
  assign rd_data_count = count_q;
  assign rd_rst_busy   = busy_q;

endmodule

// File: tb/tb_scanline_fifo_fwft.sv
// Bench for scanline_fifo_fwft: queue-based reference model compared on
// every cycle, plus directed phases with literal expectations.
module tb_scanline_fifo_fwft;
  localparam int DEPTH = 512;
  localparam int W     = 128;
  localparam int CW    = 10;
  localparam int PFT   = 500;
  localparam int PET   = 10;
  localparam int BUSY  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, rst, wr_en, rd_en;
  logic [W-1:0]  din;
  logic          full, almost_full, prog_full, wr_ack, overflow, wr_rst_busy;
  logic          empty, almost_empty, prog_empty, data_valid, underflow, rd_rst_busy;
  logic [W-1:0]  dout;
  logic [CW-1:0] wr_data_count, rd_data_count;

  scanline_fifo_fwft dut (
    .clk(clk), .reset_n(reset_n), .rst(rst), .wr_en(wr_en), .din(din),
    .full(full), .almost_full(almost_full), .prog_full(prog_full),
    .wr_ack(wr_ack), .overflow(overflow), .wr_data_count(wr_data_count),
    .wr_rst_busy(wr_rst_busy), .rd_en(rd_en), .dout(dout), .empty(empty),
    .almost_empty(almost_empty), .prog_empty(prog_empty),
    .data_valid(data_valid), .underflow(underflow),
    .rd_data_count(rd_data_count), .rd_rst_busy(rd_rst_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stored words in order, each with the edge number on which it was written.
  // The head is visible on dout once it was written on an earlier edge.
  logic [W-1:0] exp_q[$];
  int           stamp_q[$];
  int           edge_no = 0;
  int           since   = 0;
  bit           model_ok = 0;
  logic [W-1:0] exp_dout;
  bit exp_busy, exp_full, exp_empty, exp_wr_ack, exp_ovf, exp_udf;

  always @(posedge clk) begin
    bit rs, wr_ok, rd_ok, vis;
    int sz;
    rs = !reset_n || rst;
    edge_no++;
    if (rs) begin
      exp_q.delete();
      stamp_q.delete();
      since      = 0;
      model_ok   = 1;
      exp_wr_ack = 0;
      exp_ovf    = 0;
      exp_udf    = 0;
      exp_dout   = '0;
    end else if (model_ok) begin
      wr_ok      = wr_en && !exp_busy && !exp_full;
      rd_ok      = rd_en && !exp_busy && !exp_empty;
      exp_wr_ack = wr_ok;
      exp_ovf    = wr_en && exp_full && !exp_busy;
      exp_udf    = rd_en && exp_empty && !exp_busy;
      if (rd_ok) begin
        void'(exp_q.pop_front());
        void'(stamp_q.pop_front());
      end
      if (wr_ok) begin
        exp_q.push_back(din);
        stamp_q.push_back(edge_no);
      end
      since++;
    end
    if (model_ok) begin
      sz        = exp_q.size();
      exp_busy  = rs || since <= BUSY;
      exp_full  = exp_busy || sz == DEPTH;
      vis       = sz > 0 && stamp_q[0] <= edge_no - 1;
      if (vis) exp_dout = exp_q[0];
      exp_empty = !vis;
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clk) begin
    int sz;
    if (model_ok) begin
      sz = exp_q.size();
      chk("full",          W'(full),          W'(exp_full));
      chk("almost_full",   W'(almost_full),   W'(exp_busy || sz >= DEPTH - 1));
      chk("prog_full",     W'(prog_full),     W'(exp_busy || sz >= PFT));
      chk("wr_ack",        W'(wr_ack),        W'(exp_wr_ack));
      chk("overflow",      W'(overflow),      W'(exp_ovf));
      chk("wr_data_count", W'(wr_data_count), W'(sz));
      chk("rd_data_count", W'(rd_data_count), W'(sz));
      chk("wr_rst_busy",   W'(wr_rst_busy),   W'(exp_busy));
      chk("rd_rst_busy",   W'(rd_rst_busy),   W'(exp_busy));
      chk("empty",         W'(empty),         W'(exp_empty));
      chk("data_valid",    W'(data_valid),    W'(!exp_empty));
      chk("almost_empty",  W'(almost_empty),  W'(sz <= 1));
      chk("prog_empty",    W'(prog_empty),    W'(sz <= PET));
      chk("underflow",     W'(underflow),     W'(exp_udf));
      chk("dout",          dout,              exp_dout);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    rd_en = 1;
    for (int i = 0; i < DEPTH + 10 && !done; i++) begin
      tick();
      if (empty) done = 1;
    end
    rd_en = 0;
    chk(name, W'(done), W'(1));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit seen;
    reset_n = 0; rst = 0; wr_en = 0; rd_en = 0; din = '0;

    // Reset: three cycles low, then busy must last four more cycles.
    tick();
    chk("rst_busy", W'(wr_rst_busy), W'(1));
    chk("rst_full", W'(full), W'(1));
    chk("rst_dout", dout, W'(0));
    tick(); tick();
    reset_n = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rel_busy_hi", W'(wr_rst_busy), W'(1));
    end
    tick();
    chk("rel_busy_lo", W'(wr_rst_busy), W'(0));
    chk("rel_full_lo", W'(full), W'(0));
    chk("rel_count",   W'(wr_data_count), W'(0));
    chk("rel_empty",   W'(empty), W'(1));

    // FWFT ordering.
    wr_en = 1;
    din = W'(32'hA); tick(); chk("ack_a", W'(wr_ack), W'(1)); chk("lat_empty", W'(empty), W'(1));
    din = W'(32'hB); tick(); chk("ack_b", W'(wr_ack), W'(1));
    din = W'(32'hC); tick(); chk("ack_c", W'(wr_ack), W'(1));
    wr_en = 0; tick();
    chk("fwft_head", dout, W'(32'hA));
    chk("fwft_cnt",  W'(wr_data_count), W'(3));
    rd_en = 1;
    tick(); chk("pop_b", dout, W'(32'hB));
    tick(); chk("pop_c", dout, W'(32'hC));
    tick(); chk("pop_empty", W'(empty), W'(1)); chk("pop_cnt", W'(rd_data_count), W'(0));
    rd_en = 0; tick();

    // Fill to full.
    wr_en = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      din = W'(i - 1);
      tick();
      if (i == 499) chk("pf_499",  W'(prog_full), W'(0));
      if (i == 500) chk("pf_500",  W'(prog_full), W'(1));
      if (i == 510) chk("af_510",  W'(almost_full), W'(0));
      if (i == 511) begin chk("af_511", W'(almost_full), W'(1)); chk("full_511", W'(full), W'(0)); end
      if (i == 512) begin chk("full_512", W'(full), W'(1)); chk("cnt_512", W'(wr_data_count), W'(512)); end
    end
    din = W'(32'd9999); tick();
    chk("ovf_513", W'(overflow), W'(1));
    chk("cnt_513", W'(wr_data_count), W'(512));
    // Write and read together while full: read wins, write overflows.
    rd_en = 1; din = W'(32'd777); tick();
    chk("sim_full_ovf",  W'(overflow), W'(1));
    chk("sim_full_cnt",  W'(wr_data_count), W'(511));
    chk("sim_full_dout", dout, W'(1));
    rd_en = 0; din = W'(32'd999); tick();
    chk("refill_full", W'(full), W'(1));
    wr_en = 0; rd_en = 1; tick();
    chk("one_rd_full", W'(full), W'(0));
    chk("one_rd_cnt",  W'(wr_data_count), W'(511));
    drain("drain_full");

    // Underflow on empty FIFO: dout held at last popped word.
    rd_en = 1; tick();
    chk("udf_pulse", W'(underflow), W'(1));
    chk("udf_dout",  dout, W'(32'd999));
    chk("udf_cnt",   W'(wr_data_count), W'(0));
    rd_en = 0; tick();

    // Flush handshake.
    wr_en = 1;
    for (int i = 0; i < 20; i++) begin din = W'(100 + i); tick(); end
    wr_en = 0;
    rst = 1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (wr_rst_busy) seen = 1;
    end
    chk("flush_busy_seen", W'(seen), W'(1));
    rst = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("flush_busy_hi", W'(wr_rst_busy), W'(1));
    end
    tick();
    chk("flush_busy_lo", W'(wr_rst_busy), W'(0));
    chk("flush_empty",   W'(empty), W'(1));
    chk("flush_cnt",     W'(wr_data_count), W'(0));
    wr_en = 1; din = W'(32'h55); tick();
    wr_en = 0;
    chk("flush_lat", W'(empty), W'(1));
    tick();
    chk("flush_dout", dout, W'(32'h55));
    chk("flush_cnt1", W'(wr_data_count), W'(1));
    rd_en = 1; tick(); rd_en = 0; tick();

    // Simultaneous write and read at count 5.
    wr_en = 1;
    for (int i = 0; i < 5; i++) begin din = W'(200 + i); tick(); end
    wr_en = 0; tick();
    wr_en = 1; rd_en = 1; din = W'(205); tick();
    chk("sim5_cnt",  W'(wr_data_count), W'(5));
    chk("sim5_dout", dout, W'(201));
    wr_en = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 4) chk("sim5_order", dout, W'(202 + k));
      else       chk("sim5_empty", W'(empty), W'(1));
    end
    rd_en = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
